// File: rtl/casu_ep_cfg_master.sv
// Peripheral-bus initiator that programs the CASU ER_min/ER_max pair.
// Range-checks the request, writes both words, optionally reads them back.
module casu_ep_cfg_master #(
   parameter logic [14:0] BASE_ADDR = 15'h0070
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_min,
   input  logic [15:0] req_max,
   input  logic        req_verify,
   input  logic        per_stall,
   input  logic [15:0] per_rdata,
   output logic [13:0] per_addr,
   output logic [15:0] per_din,
   output logic        per_en,
   output logic [1:0]  per_we,
   output logic        busy,
   output logic        done,
   output logic [1:0]  status
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_MIN,
      S_WR_MAX,
      S_RD_MIN,
      S_RD_MAX,
      S_DONE
   } state_t;

   localparam logic [13:0] ADDR_MIN = BASE_ADDR[14:1];
   localparam logic [13:0] ADDR_MAX = BASE_ADDR[14:1] + 14'd1;

   state_t      state_q, state_d;
   logic [15:0] min_q, min_d;
   logic [15:0] max_q, max_d;
   logic        verify_q, verify_d;
   logic        mismatch_q, mismatch_d;
   logic [1:0]  status_q, status_d;

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         state_q    <= S_IDLE;
         min_q      <= 16'h0000;
         max_q      <= 16'h0000;
         verify_q   <= 1'b0;
         mismatch_q <= 1'b0;
         status_q   <= 2'b00;
      end else begin
         state_q    <= state_d;
         min_q      <= min_d;
         max_q      <= max_d;
         verify_q   <= verify_d;
         mismatch_q <= mismatch_d;
         status_q   <= status_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      min_d      = min_q;
      max_d      = max_q;
      verify_d   = verify_q;
      mismatch_d = mismatch_q;
      status_d   = status_q;
      per_addr   = 14'h0000;
      per_din    = 16'h0000;
      per_en     = 1'b0;
      per_we     = 2'b00;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               min_d      = req_min;
               max_d      = req_max;
               verify_d   = req_verify;
               mismatch_d = 1'b0;
               if (req_min > req_max) begin
                  status_d = 2'b01;
                  state_d  = S_DONE;
               end else begin
                  status_d = 2'b00;
                  state_d  = S_WR_MIN;
               end
            end
         end
         S_WR_MIN: begin
            per_en   = ~per_stall;
            per_we   = {2{~per_stall}};
            per_addr = ADDR_MIN;
            per_din  = min_q;
            if (!per_stall) state_d = S_WR_MAX;
         end
         S_WR_MAX: begin
            per_en   = ~per_stall;
            per_we   = {2{~per_stall}};
            per_addr = ADDR_MAX;
            per_din  = max_q;
            if (!per_stall) state_d = verify_q ? S_RD_MIN : S_DONE;
         end
         S_RD_MIN: begin
            per_en   = ~per_stall;
            per_addr = ADDR_MIN;
            if (!per_stall) begin
               if (per_rdata != min_q) mismatch_d = 1'b1;
               state_d = S_RD_MAX;
            end
         end
         S_RD_MAX: begin
            per_en   = ~per_stall;
            per_addr = ADDR_MAX;
            // Final status folds in this last sample so it is valid with done.
            if (!per_stall) begin
               if (mismatch_q || (per_rdata != max_q)) begin
                  mismatch_d = 1'b1;
                  status_d   = 2'b10;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = ~req_ready;
   assign done      = (state_q == S_DONE);
   assign status    = status_q;

endmodule

// File: tb/tb_casu_ep_cfg_master.sv
// Bench for casu_ep_cfg_master: EP register responder plus a per-request
// model of the expected bus cycles, status and completion latency.
module tb_casu_ep_cfg_master;

   localparam logic [13:0] A_MIN = 14'h0038;
   localparam logic [13:0] A_MAX = 14'h0039;

   typedef struct packed {
      logic [13:0] addr;
      logic [1:0]  we;
      logic [15:0] din;
   } op_t;

   logic        mclk = 1'b0;
   logic        puc_rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_verify = 1'b0;
   logic        per_stall = 1'b0;
   logic [15:0] req_min = 16'h0000;
   logic [15:0] req_max = 16'h0000;
   logic [15:0] per_rdata;
   logic        req_ready, per_en, busy, done;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic [1:0]  per_we, status;

   logic [15:0] ep_mem [2];
   logic        corrupt_min = 1'b0;

   int checks = 0;
   int errors = 0;

   op_t exp_q[$];
   op_t obs_q[$];

   always #5 mclk = ~mclk;

   casu_ep_cfg_master #(.BASE_ADDR(15'h0070)) dut (
      .mclk      (mclk),
      .puc_rst   (puc_rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_min   (req_min),
      .req_max   (req_max),
      .req_verify(req_verify),
      .per_stall (per_stall),
      .per_rdata (per_rdata),
      .per_addr  (per_addr),
      .per_din   (per_din),
      .per_en    (per_en),
      .per_we    (per_we),
      .busy      (busy),
      .done      (done),
      .status    (status)
   );

   // EP register responder, reset by the same puc_rst, combinational read data.
   always @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         ep_mem[0] <= 16'h0000;
         ep_mem[1] <= 16'h0000;
      end else if (per_en && per_we == 2'b11) begin
         if (per_addr == A_MIN) ep_mem[0] <= per_din;
         else if (per_addr == A_MAX) ep_mem[1] <= per_din;
      end
   end

   always_comb begin
      per_rdata = 16'h0000;
      if (per_addr == A_MIN) per_rdata = corrupt_min ? 16'hE000 : ep_mem[0];
      else if (per_addr == A_MAX) per_rdata = ep_mem[1];
   end

   task automatic run_req(input logic [15:0] mn, input logic [15:0] mx, input logic vf,
                          input int st0, input int st1, input int st2, input int st3,
                          input logic bad_min, input string name);
      int stalls[4];
      int nops, exp_done, done_cyc, served, stall_left;
      logic [1:0] exp_status, got_status;
      stalls[0] = st0; stalls[1] = st1; stalls[2] = st2; stalls[3] = st3;

      exp_q.delete();
      obs_q.delete();
      if (mn > mx) begin
         exp_status = 2'b01;
      end else begin
         exp_q.push_back('{addr: A_MIN, we: 2'b11, din: mn});
         exp_q.push_back('{addr: A_MAX, we: 2'b11, din: mx});
         if (vf) begin
            exp_q.push_back('{addr: A_MIN, we: 2'b00, din: 16'h0000});
            exp_q.push_back('{addr: A_MAX, we: 2'b00, din: 16'h0000});
         end
         exp_status = (vf && bad_min && mn != 16'hE000) ? 2'b10 : 2'b00;
      end
      nops = exp_q.size();
      exp_done = nops + 1;
      for (int i = 0; i < nops; i++) exp_done += stalls[i];

      corrupt_min = bad_min;
      @(negedge mclk);
      per_stall = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before: got %b want 1", name, req_ready);
      end
      req_valid = 1'b1; req_min = mn; req_max = mx; req_verify = vf;
      @(negedge mclk);
      req_valid = 1'b0;
      req_min = 16'($urandom); req_max = 16'($urandom); req_verify = 1'($urandom);

      done_cyc = 0; served = 0; got_status = 2'b11; stall_left = stalls[0];
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) @(negedge mclk);
         per_stall = (served < nops) && (stall_left > 0);
         #1;
         checks++;
         if (req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_c%0d: ready %b busy %b want 0/1", name, k, req_ready, busy);
         end
         if (per_stall) begin
            checks++;
            if (per_en !== 1'b0 || per_we !== 2'b00 || per_addr !== exp_q[served].addr) begin
               errors++;
               $display("FAIL %s stall_c%0d: en %b we %b addr %h want 0/00/%h",
                        name, k, per_en, per_we, per_addr, exp_q[served].addr);
            end
            stall_left--;
         end
         if (per_en === 1'b1) begin
            obs_q.push_back('{addr: per_addr, we: per_we, din: per_din});
            served++;
            if (served < 4) stall_left = stalls[served];
         end
         if (done === 1'b1) begin
            done_cyc = k;
            got_status = status;
            break;
         end
      end
      per_stall = 1'b0;

      checks++;
      if (done_cyc != exp_done) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
      end
      checks++;
      if (got_status !== exp_status) begin
         errors++;
         $display("FAIL %s status: got %b want %b", name, got_status, exp_status);
      end
      checks++;
      if (obs_q.size() != nops) begin
         errors++;
         $display("FAIL %s bus_count: got %0d want %0d", name, obs_q.size(), nops);
      end else begin
         for (int i = 0; i < nops; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL %s bus_op%0d: got %h/%b/%h want %h/%b/%h", name, i,
                        obs_q[i].addr, obs_q[i].we, obs_q[i].din,
                        exp_q[i].addr, exp_q[i].we, exp_q[i].din);
            end
         end
      end

      @(negedge mclk);
      #1;
      checks++;
      if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || per_en !== 1'b0 || status !== exp_status) begin
         errors++;
         $display("FAIL %s after_done: done %b ready %b busy %b en %b status %b want 0/1/0/0/%b",
                  name, done, req_ready, busy, per_en, status, exp_status);
      end
      if (nops > 0) begin
         checks++;
         if (ep_mem[0] !== mn || ep_mem[1] !== mx) begin
            errors++;
            $display("FAIL %s ep_regs: got %h/%h want %h/%h", name, ep_mem[0], ep_mem[1], mn, mx);
         end
      end
      corrupt_min = 1'b0;
      $display("txn %s: min=%h max=%h verify=%b status=%b done_cycle=%0d", name, mn, mx, vf, got_status, done_cyc);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || status !== 2'b00 ||
          per_en !== 1'b0 || per_we !== 2'b00 || per_addr !== 14'h0 || per_din !== 16'h0) begin
         errors++;
         $display("FAIL reset: ready %b busy %b done %b status %b en %b we %b addr %h din %h",
                  req_ready, busy, done, status, per_en, per_we, per_addr, per_din);
      end
      repeat (3) @(negedge mclk);
      puc_rst = 1'b0;
   endtask

   task automatic test_write_only();
      run_req(16'hE200, 16'hEBFF, 1'b0, 0, 0, 0, 0, 1'b0, "write_only");
   endtask

   task automatic test_verify();
      run_req(16'hE200, 16'hEBFF, 1'b1, 0, 0, 0, 0, 1'b0, "verify_ok");
      run_req(16'hE200, 16'hEBFF, 1'b1, 0, 0, 0, 0, 1'b1, "verify_mismatch");
      run_req(16'h1234, 16'h1234, 1'b1, 0, 0, 0, 0, 1'b0, "min_eq_max");
   endtask

   task automatic test_range_error();
      run_req(16'hF000, 16'hE000, 1'b1, 0, 0, 0, 0, 1'b0, "range_error");
   endtask

   task automatic test_stall();
      run_req(16'hE200, 16'hEBFF, 1'b0, 0, 3, 0, 0, 1'b0, "stall_wr_max");
   endtask

   task automatic test_reset_mid();
      @(negedge mclk);
      req_valid = 1'b1; req_min = 16'hC000; req_max = 16'hC100; req_verify = 1'b1;
      repeat (3) begin
         @(negedge mclk);
         req_valid = 1'b0;
      end
      #1;
      checks++;
      if (per_en !== 1'b1 || per_addr !== A_MIN || per_we !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid_rdmin: en %b addr %h we %b want 1/%h/00", per_en, per_addr, per_we, A_MIN);
      end
      #1 puc_rst = 1'b1;
      #1;
      checks++;
      if (per_en !== 1'b0 || per_we !== 2'b00 || per_addr !== 14'h0 || per_din !== 16'h0 ||
          busy !== 1'b0 || done !== 1'b0 || status !== 2'b00 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_outputs: en %b we %b addr %h din %h busy %b done %b status %b ready %b",
                  per_en, per_we, per_addr, per_din, busy, done, status, req_ready);
      end
      @(negedge mclk);
      puc_rst = 1'b0;
      run_req(16'h0100, 16'h0200, 1'b1, 0, 0, 0, 0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      logic [15:0] mn, mx, t;
      for (int n = 0; n < 25; n++) begin
         mn = 16'($urandom);
         mx = 16'($urandom);
         if ($urandom_range(0, 3) != 0 && mn > mx) begin
            t = mn; mn = mx; mx = t;
         end
         run_req(mn, mx, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 3) == 0), "random");
      end
   endtask

   initial begin
      test_reset();
      test_write_only();
      test_verify();
      test_range_error();
      test_stall();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
